// File: rtl/stereo_row_disparity.sv
// Streaming stereo block matcher: buffers one row of L/R pixels, then searches
// a disparity range per column with a horizontal SSD/SAD window, one tap per cycle.
module stereo_row_disparity #(
  parameter int WIDTH    = 320,
  parameter int PIX_W    = 8,
  parameter int WIN      = 7,
  parameter int MIN_DISP = 0,
  parameter int MAX_DISP = 10,
  parameter int D_W      = 5,
  parameter int ACC_W    = 2*PIX_W+$clog2(WIN)+1
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     cost_sel,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [PIX_W-1:0]         s_pix_l,
  input  logic [PIX_W-1:0]         s_pix_r,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [D_W-1:0]           m_disp,
  output logic [$clog2(WIDTH)-1:0] m_col,
  output logic                     m_eol,
  output logic                     busy
);
  localparam int CW = $clog2(WIDTH);
  localparam int KW = $clog2(WIN+1);
  localparam int H  = (WIN-1)/2;
  localparam int IW = CW+3;
  localparam logic signed [IW-1:0] HS   = IW'(H);
  localparam logic signed [IW-1:0] MAXI = IW'(WIDTH-1);

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_OUT} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      wr_ptr_q, wr_ptr_d, col_q, col_d, m_col_q, m_col_d;
  logic [D_W-1:0]     d_q, d_d, best_d_q, best_d_d, m_disp_q, m_disp_d;
  logic [KW-1:0]      k_q, k_d;
  logic [ACC_W-1:0]   acc_q, acc_d, best_cost_q, best_cost_d;
  logic               sel_q, sel_d, m_valid_q, m_valid_d, m_eol_q, m_eol_d;

  logic [PIX_W-1:0]   buf_l [WIDTH];
  logic [PIX_W-1:0]   buf_r [WIDTH];

  logic signed [IW-1:0] li_s, ri_s;
  logic [CW-1:0]        li, ri;
  logic signed [PIX_W:0] diff;
  logic [ACC_W-1:0]     tap, cost;
  logic                 upd;

  // Out-of-row taps replicate the edge pixel.
  function automatic logic [CW-1:0] clamp_idx(input logic signed [IW-1:0] v);
    if (v < 0)         return '0;
    else if (v > MAXI) return CW'(WIDTH-1);
    else               return v[CW-1:0];
  endfunction

  function automatic logic [ACC_W-1:0] tap_cost(input logic signed [PIX_W:0] df,
                                                input logic sad);
    logic signed [2*PIX_W+1:0] sq;
    logic [PIX_W:0]            mag;
    sq  = df * df;
    mag = (df < 0) ? $unsigned(-df) : $unsigned(df);
    return sad ? ACC_W'(mag) : ACC_W'($unsigned(sq));
  endfunction

  always_comb begin
    li_s = $signed({{(IW-CW){1'b0}}, col_q}) + $signed({{(IW-KW){1'b0}}, k_q}) - HS;
    ri_s = li_s - $signed({{(IW-D_W){1'b0}}, d_q});
    li   = clamp_idx(li_s);
    ri   = clamp_idx(ri_s);
    diff = $signed({1'b0, buf_l[li]}) - $signed({1'b0, buf_r[ri]});
    tap  = tap_cost(diff, sel_q);
    cost = ((k_q == '0) ? '0 : acc_q) + tap;
    upd  = (d_q == D_W'(MIN_DISP)) || (cost < best_cost_q);
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    col_d       = col_q;
    d_d         = d_q;
    k_d         = k_q;
    acc_d       = acc_q;
    best_cost_d = best_cost_q;
    best_d_d    = best_d_q;
    sel_d       = sel_q;
    m_valid_d   = m_valid_q;
    m_disp_d    = m_disp_q;
    m_col_d     = m_col_q;
    m_eol_d     = m_eol_q;
    case (state_q)
      S_LOAD: begin
        if (s_valid) begin
          if (wr_ptr_q == CW'(WIDTH-1)) begin
            wr_ptr_d = '0;
            col_d    = '0;
            d_d      = D_W'(MIN_DISP);
            k_d      = '0;
            sel_d    = cost_sel;
            state_d  = S_CALC;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      S_CALC: begin
        acc_d = cost;
        if (k_q == KW'(WIN-1)) begin
          k_d = '0;
          if (upd) begin
            best_cost_d = cost;
            best_d_d    = d_q;
          end
          if (d_q == D_W'(MAX_DISP)) begin
            m_valid_d = 1'b1;
            m_disp_d  = upd ? d_q : best_d_q;
            m_col_d   = col_q;
            m_eol_d   = (col_q == CW'(WIDTH-1));
            state_d   = S_OUT;
          end else begin
            d_d = d_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          if (m_eol_q) begin
            state_d = S_LOAD;
          end else begin
            col_d   = col_q + 1'b1;
            d_d     = D_W'(MIN_DISP);
            k_d     = '0;
            sel_d   = cost_sel;
            state_d = S_CALC;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= S_LOAD;
      wr_ptr_q    <= '0;
      col_q       <= '0;
      d_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      best_cost_q <= '0;
      best_d_q    <= '0;
      sel_q       <= 1'b0;
      m_valid_q   <= 1'b0;
      m_disp_q    <= '0;
      m_col_q     <= '0;
      m_eol_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      col_q       <= col_d;
      d_q         <= d_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      best_cost_q <= best_cost_d;
      best_d_q    <= best_d_d;
      sel_q       <= sel_d;
      m_valid_q   <= m_valid_d;
      m_disp_q    <= m_disp_d;
      m_col_q     <= m_col_d;
      m_eol_q     <= m_eol_d;
    end
  end

  // Row buffers hold pixel data only; they are never cleared.
  always_ff @(posedge HCLK) begin
    if (state_q == S_LOAD && s_valid) begin
      buf_l[wr_ptr_q] <= s_pix_l;
      buf_r[wr_ptr_q] <= s_pix_r;
    end
  end

  assign s_ready = (state_q == S_LOAD);
  assign busy    = (state_q != S_LOAD);
  assign m_valid = m_valid_q;
  assign m_disp  = m_disp_q;
  assign m_col   = m_col_q;
  assign m_eol   = m_eol_q;
endmodule

// File: tb/tb_stereo_row_disparity.sv
// Bench for stereo_row_disparity: randomized rows and backpressure against a
// window-cost reference model computed directly from the matching rules.
module tb_stereo_row_disparity;
  localparam int WIDTH    = 32;
  localparam int PIX_W    = 8;
  localparam int WIN      = 7;
  localparam int MIN_DISP = 0;
  localparam int MAX_DISP = 10;
  localparam int D_W      = 5;
  localparam int H        = (WIN-1)/2;
  localparam int NDISP    = MAX_DISP-MIN_DISP+1;
  localparam int CW       = $clog2(WIDTH);

  logic             HCLK = 0;
  logic             HRESETn = 0;
  logic             cost_sel = 0;
  logic             s_valid = 0;
  logic             s_ready;
  logic [PIX_W-1:0] s_pix_l = 0;
  logic [PIX_W-1:0] s_pix_r = 0;
  logic             m_valid;
  logic             m_ready = 0;
  logic [D_W-1:0]   m_disp;
  logic [CW-1:0]    m_col;
  logic             m_eol;
  logic             busy;

  int total = 0;
  int bad   = 0;
  int lrow [WIDTH];
  int rrow [WIDTH];

  stereo_row_disparity #(
    .WIDTH(WIDTH), .PIX_W(PIX_W), .WIN(WIN),
    .MIN_DISP(MIN_DISP), .MAX_DISP(MAX_DISP), .D_W(D_W)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .cost_sel(cost_sel),
    .s_valid(s_valid), .s_ready(s_ready), .s_pix_l(s_pix_l), .s_pix_r(s_pix_r),
    .m_valid(m_valid), .m_ready(m_ready), .m_disp(m_disp), .m_col(m_col),
    .m_eol(m_eol), .busy(busy)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int x);
    return (x < 0) ? 0 : ((x > WIDTH-1) ? WIDTH-1 : x);
  endfunction

  // Best disparity for a column: minimum window cost, first (smallest d) on ties.
  function automatic int ref_disp(input int c, input bit sad);
    int best = MIN_DISP;
    longint best_cost = 0;
    for (int d = MIN_DISP; d <= MAX_DISP; d++) begin
      longint cst = 0;
      for (int o = -H; o <= H; o++) begin
        int df = lrow[clampi(c+o)] - rrow[clampi(c+o-d)];
        cst += sad ? ((df < 0) ? -df : df) : df*df;
      end
      if (d == MIN_DISP || cst < best_cost) begin
        best_cost = cst;
        best = d;
      end
    end
    return best;
  endfunction

  task automatic tick();
    @(posedge HCLK); #1;
  endtask

  task automatic load_row(input bit sad);
    int i = 0;
    int guard = 0;
    bit hs;
    cost_sel = sad;
    while (i < WIDTH && guard < 20*WIDTH) begin
      s_valid = ($urandom_range(3) != 0);
      s_pix_l = PIX_W'(lrow[i]);
      s_pix_r = PIX_W'(rrow[i]);
      hs = s_valid && s_ready;
      tick();
      guard++;
      if (hs) i++;
    end
    s_valid = 0;
    if (i < WIDTH) chk("load_timeout", i, WIDTH);
  endtask

  // rmode 0: m_ready always high; 1: random backpressure.
  task automatic run_row(input bit sad, input int rmode, input bit flip,
                         input int stall_col, input int abort_col);
    int col = 0, cyc = 0, seen = -1, last_t = 0, stall = 0, expd = 0;
    while (col < WIDTH) begin
      if (abort_col >= 0 && col == abort_col) break;
      if (cyc > WIDTH*(NDISP*WIN+40)) begin
        chk("out_timeout", col, WIDTH);
        break;
      end
      if (m_valid && col == stall_col && stall < 10) begin
        m_ready = 0;
        stall++;
      end else if (rmode == 1) begin
        m_ready = 1'($urandom_range(1));
      end else begin
        m_ready = 1;
      end
      cost_sel = (flip && !(m_valid && m_ready)) ? ~sad : sad;
      if (m_valid) begin
        if (seen != col) begin
          seen = col;
          expd = ref_disp(col, sad);
          chk("disp", m_disp, expd);
          chk("col", m_col, col);
          chk("eol", m_eol, (col == WIDTH-1) ? 1 : 0);
          chk("busy_out", busy, 1);
          if (rmode == 0 && stall_col < 0)
            chk("period", cyc - last_t, (col == 0) ? NDISP*WIN : NDISP*WIN+1);
          last_t = cyc;
        end else begin
          chk("hold_disp", m_disp, expd);
          chk("hold_col", m_col, col);
          chk("hold_srdy", s_ready, 0);
        end
        if (m_ready) col++;
      end
      tick();
      cyc++;
    end
    m_ready = 0;
    if (abort_col < 0) begin
      chk("srdy_after_eol", s_ready, 1);
      chk("busy_after_eol", busy, 0);
      chk("mvalid_after_eol", m_valid, 0);
    end
  endtask

  initial begin
    repeat (3) tick();
    HRESETn = 1;
    tick();
    chk("rst_srdy", s_ready, 1);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_disp", m_disp, 0);
    chk("rst_col", m_col, 0);
    chk("rst_eol", m_eol, 0);
    chk("rst_busy", busy, 0);

    // identical ramp rows, SSD
    for (int i = 0; i < WIDTH; i++) begin lrow[i] = i; rrow[i] = i; end
    load_row(0);
    run_row(0, 0, 0, -1, -1);

    // right row is left shifted by 3, SAD
    for (int i = 0; i < WIDTH; i++) lrow[i] = $urandom_range(255);
    for (int i = 0; i < WIDTH; i++) rrow[i] = (i+3 < WIDTH) ? lrow[i+3] : $urandom_range(255);
    load_row(1);
    run_row(1, 0, 0, -1, -1);

    // constant rows: all costs tie at zero; stall on column 5
    for (int i = 0; i < WIDTH; i++) begin lrow[i] = 50; rrow[i] = 50; end
    load_row(1);
    run_row(1, 1, 0, 5, -1);

    // random rows, SSD, cost_sel toggled while calculating
    for (int i = 0; i < WIDTH; i++) begin
      lrow[i] = $urandom_range(255);
      rrow[i] = $urandom_range(255);
    end
    load_row(0);
    run_row(0, 1, 1, -1, -1);

    // abort mid-row with a one-cycle reset
    load_row(1);
    run_row(1, 0, 0, -1, 20);
    repeat (30) tick();
    chk("pre_rst_busy", busy, 1);
    HRESETn = 0;
    tick();
    HRESETn = 1;
    chk("midrst_mvalid", m_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_srdy", s_ready, 1);
    for (int i = 0; i < WIDTH; i++) begin
      lrow[i] = $urandom_range(255);
      rrow[i] = $urandom_range(255);
    end
    load_row(1);
    run_row(1, 0, 0, -1, -1);

    // saturation corner: maximal differences everywhere, SSD
    for (int i = 0; i < WIDTH; i++) begin lrow[i] = 255; rrow[i] = 0; end
    load_row(0);
    run_row(0, 0, 0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
